// File: rtl/ksa_pkg.sv
// Shared widths, requester indices and arbiter state type for the RC4/KSA datapath.
package ksa_pkg;

    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    localparam int REQ_INIT    = 0;
    localparam int REQ_SHUFFLE = 1;
    localparam int REQ_SREAD   = 2;
    localparam int REQ_DECRYPT = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester found searching from last+1, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    int               idx;
    logic [IDX_W-1:0] idx_v;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        idx_v  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            // Explicit wrap keeps the index in range for non-power-of-2 N_REQ.
            idx = int'(last) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_v = IDX_W'(idx);
            if (!any && req[idx_v]) begin
                winner = idx_v;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/s_mem_arbiter.sv
// Burst-granting round-robin arbiter for the single-port S memory, with a tagged
// read-valid pipeline that returns each read strobe to the requester that issued it.
module s_mem_arbiter
    import ksa_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int ADDR_W       = S_ADDR_W,
    parameter int DATA_W       = S_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic                      CLOCK_50,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    input  logic [N_REQ-1:0]          req_wren,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic [2:0]                owner_id,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_wren,
    input  logic [DATA_W-1:0]         mem_q
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] pick_last, pick_winner;
    logic             pick_any;
    logic             owned, owner_req, rd_push;

    logic             tag_v_q  [READ_LATENCY];
    logic [IDX_W-1:0] tag_id_q [READ_LATENCY];

    assign owned     = (state_q == ARB_OWNED);
    assign owner_req = owned && req[owner_q];
    assign rd_push   = owner_req && !req_wren[owner_q];

    // One selector serves both decisions: from IDLE search past last, on release past owner.
    assign pick_last = owned ? owner_q : last_q;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .last   (pick_last),
        .winner (pick_winner),
        .any    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (clear) begin
            state_d = ARB_IDLE;
            owner_d = '0;
            last_d  = IDX_W'(N_REQ - 1);
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state_d = ARB_OWNED;
                        owner_d = pick_winner;
                    end
                end
                ARB_OWNED: begin
                    if (!req[owner_q]) begin
                        last_d = owner_q;
                        if (pick_any) begin
                            owner_d = pick_winner;
                        end else begin
                            state_d = ARB_IDLE;
                            owner_d = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Memory port is zeroed unless the owner is still holding req, so the release cycle cannot write.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        if (owner_req) begin
            mem_addr  = req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[int'(owner_q)*DATA_W +: DATA_W];
            mem_wren  = req_wren[owner_q];
        end
    end

    always_comb begin
        gnt = '0;
        if (owned) begin
            gnt[owner_q] = 1'b1;
        end
    end

    assign busy     = owned;
    assign owner_id = 3'(owner_q);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_v_q[i]  <= 1'b0;
                tag_id_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_v_q[i]  <= 1'b0;
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_v_q[0]  <= rd_push;
            tag_id_q[0] <= owner_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    // Tags travel independently of ownership, so a read outlives a handover.
    always_comb begin
        rd_valid = '0;
        if (tag_v_q[READ_LATENCY-1]) begin
            rd_valid[tag_id_q[READ_LATENCY-1]] = 1'b1;
        end
    end

    assign rd_data = mem_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Bench for s_mem_arbiter: two instances (read latency 1 and 2) share one stimulus stream,
// each backed by its own S memory model; read strobes are scoreboarded per instance.
module tb_s_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic clear;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus signals ----------------
    logic [N-1:0]    req;
    logic [N-1:0]    wren;
    logic [AW-1:0]   addr  [N];
    logic [DW-1:0]   wdata [N];
    logic [N*AW-1:0] req_addr_p;
    logic [N*DW-1:0] req_wdata_p;

    always_comb begin
        req_addr_p  = '0;
        req_wdata_p = '0;
        for (int i = 0; i < N; i++) begin
            req_addr_p[i*AW +: AW]  = addr[i];
            req_wdata_p[i*DW +: DW] = wdata[i];
        end
    end

    logic [N-1:0]  gnt1, gnt2, rd_valid1, rd_valid2;
    logic [DW-1:0] rd_data1, rd_data2, mem_wdata1, mem_wdata2, mem_q1, mem_q2, q2_stage;
    logic [AW-1:0] mem_addr1, mem_addr2;
    logic [2:0]    owner_id1, owner_id2;
    logic          busy1, busy2, mem_wren1, mem_wren2;

    s_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_dut1 (
        .CLOCK_50 (clk),        .reset_n  (reset_n),     .clear    (clear),
        .req      (req),        .req_addr (req_addr_p),  .req_wdata(req_wdata_p),
        .req_wren (wren),       .gnt      (gnt1),        .rd_valid (rd_valid1),
        .rd_data  (rd_data1),   .busy     (busy1),       .owner_id (owner_id1),
        .mem_addr (mem_addr1),  .mem_wdata(mem_wdata1),  .mem_wren (mem_wren1),
        .mem_q    (mem_q1)
    );

    s_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) u_dut2 (
        .CLOCK_50 (clk),        .reset_n  (reset_n),     .clear    (clear),
        .req      (req),        .req_addr (req_addr_p),  .req_wdata(req_wdata_p),
        .req_wren (wren),       .gnt      (gnt2),        .rd_valid (rd_valid2),
        .rd_data  (rd_data2),   .busy     (busy2),       .owner_id (owner_id2),
        .mem_addr (mem_addr2),  .mem_wdata(mem_wdata2),  .mem_wren (mem_wren2),
        .mem_q    (mem_q2)
    );

    // S memory models: synchronous read, 1 and 2 cycles of latency.
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] mem2 [256];

    always @(posedge clk) begin
        if (mem_wren1) mem1[mem_addr1] <= mem_wdata1;
        mem_q1 <= mem1[mem_addr1];
    end

    always @(posedge clk) begin
        if (mem_wren2) mem2[mem_addr2] <= mem_wdata2;
        q2_stage <= mem2[mem_addr2];
        mem_q2   <= q2_stage;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [31:0] o1, input logic [31:0] o2,
                            input logic [31:0] exp);
        chk({tag, "_l1"}, o1, exp);
        chk({tag, "_l2"}, o2, exp);
    endtask

    // Scoreboard entries: {due cycle[15:0], rd_valid[3:0], data[7:0]}
    logic [27:0] exp_q1[$];
    logic [27:0] exp_q2[$];
    logic [27:0] e1, e2;

    task automatic push_read(input int who, input logic [7:0] data, input bit to_l2);
        logic [3:0] oh;
        oh = 4'b0001 << who;
        exp_q1.push_back({16'(cyc + 1), oh, data});
        if (to_l2) exp_q2.push_back({16'(cyc + 2), oh, data});
    endtask

    always @(negedge clk) begin
        if (exp_q1.size() > 0 && exp_q1[0][27:12] == 16'(cyc)) begin
            e1 = exp_q1.pop_front();
            chk("rd_valid_l1", rd_valid1, e1[11:8]);
            chk("rd_data_l1", rd_data1, e1[7:0]);
        end else begin
            chk("rd_idle_l1", rd_valid1, 0);
        end
        if (exp_q2.size() > 0 && exp_q2[0][27:12] == 16'(cyc)) begin
            e2 = exp_q2.pop_front();
            chk("rd_valid_l2", rd_valid2, e2[11:8]);
            chk("rd_data_l2", rd_data2, e2[7:0]);
        end else begin
            chk("rd_idle_l2", rd_valid2, 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        req     = '0;
        wren    = '0;
        for (int i = 0; i < N; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_both("rst_gnt", gnt1, gnt2, 0);
        chk_both("rst_busy", busy1, busy2, 0);
        chk_both("rst_owner", owner_id1, owner_id2, 0);
        chk_both("rst_wren", mem_wren1, mem_wren2, 0);
        chk_both("rst_addr", mem_addr1, mem_addr2, 0);
        reset_n = 1'b1;
        tick();

        // Requester 0 wins first and fills S with s[i]=i.
        req[0] = 1'b1;
        #1;
        chk_both("idle_wren", mem_wren1, mem_wren2, 0);
        tick();
        chk_both("g0_gnt", gnt1, gnt2, 4'b0001);
        chk_both("g0_owner", owner_id1, owner_id2, 0);
        chk_both("g0_busy", busy1, busy2, 1);
        for (int a = 0; a < 256; a++) begin
            addr[0]  = 8'(a);
            wdata[0] = 8'(a);
            wren[0]  = 1'b1;
            #1;
            chk_both("fill_wren", mem_wren1, mem_wren2, 1);
            chk_both("fill_addr", mem_addr1, mem_addr2, a);
            chk_both("fill_wdata", mem_wdata1, mem_wdata2, a);
            tick();
        end
        req[0]  = 1'b0;
        wren[0] = 1'b0;
        #1;
        chk_both("rel0_wren", mem_wren1, mem_wren2, 0);
        chk_both("rel0_addr", mem_addr1, mem_addr2, 0);
        chk_both("rel0_gnt", gnt1, gnt2, 4'b0001);
        tick();
        chk_both("idle0_busy", busy1, busy2, 0);
        chk_both("idle0_gnt", gnt1, gnt2, 0);

        // Requester 2 reads address 5.
        req[2]  = 1'b1;
        addr[2] = 8'd5;
        tick();
        chk_both("g2_gnt", gnt1, gnt2, 4'b0100);
        chk_both("g2_owner", owner_id1, owner_id2, 2);
        push_read(2, 8'h05, 1'b1);
        tick();
        req[2] = 1'b0;
        #1;
        chk_both("rel2_addr", mem_addr1, mem_addr2, 0);
        tick();
        chk_both("idle2_busy", busy1, busy2, 0);

        // Owner 1 writes, requester 3 drives a stray write that must be ignored.
        req[1]   = 1'b1;
        addr[1]  = 8'd20;
        wdata[1] = 8'h5A;
        wren[1]  = 1'b1;
        tick();
        chk_both("g1_gnt", gnt1, gnt2, 4'b0010);
        req[3]   = 1'b1;
        wren[3]  = 1'b1;
        addr[3]  = 8'd9;
        wdata[3] = 8'hAA;
        #1;
        chk_both("w1_wren", mem_wren1, mem_wren2, 1);
        chk_both("w1_addr", mem_addr1, mem_addr2, 20);
        chk_both("w1_wdata", mem_wdata1, mem_wdata2, 8'h5A);
        tick();
        addr[1] = 8'd7;
        wren[1] = 1'b0;
        push_read(1, 8'h07, 1'b1);
        #1;
        chk_both("r1_wren", mem_wren1, mem_wren2, 0);
        chk_both("r1_addr", mem_addr1, mem_addr2, 7);
        tick();
        req[1] = 1'b0;
        #1;
        chk_both("rel1_gnt", gnt1, gnt2, 4'b0010);
        chk_both("rel1_wren", mem_wren1, mem_wren2, 0);
        tick();
        chk_both("ho3_gnt", gnt1, gnt2, 4'b1000);
        chk("ho3_rdv_l2", rd_valid2, 4'b0010);
        wren[3] = 1'b0;
        push_read(3, 8'h09, 1'b1);
        #1;
        chk_both("r3_addr", mem_addr1, mem_addr2, 9);
        chk_both("r3_wren", mem_wren1, mem_wren2, 0);
        tick();
        addr[3] = 8'd20;
        push_read(3, 8'h5A, 1'b1);
        tick();
        req[3] = 1'b0;
        tick();
        chk_both("idle3_busy", busy1, busy2, 0);

        // All four requesting: 0,1,2,3,0 with zero-idle handovers.
        req  = 4'b1111;
        wren = '0;
        for (int i = 0; i < N; i++) addr[i] = 8'(8'h40 + i);
        tick();
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % N;
            chk_both("rr_gnt", gnt1, gnt2, 4'b0001 << e);
            chk_both("rr_owner", owner_id1, owner_id2, e);
            for (int j = 0; j < 3; j++) begin
                push_read(e, 8'(8'h40 + e), 1'b1);
                tick();
            end
            if (k == 4) req = '0;
            else        req[e] = 1'b0;
            #1;
            chk_both("rr_rel_wren", mem_wren1, mem_wren2, 0);
            chk_both("rr_rel_addr", mem_addr1, mem_addr2, 0);
            chk_both("rr_rel_busy", busy1, busy2, 1);
            tick();
            if (k < 4) req[e] = 1'b1;
        end
        chk_both("rr_end_busy", busy1, busy2, 0);
        chk_both("rr_end_gnt", gnt1, gnt2, 0);

        // Asynchronous reset in the middle of a write burst by owner 1.
        req[1]   = 1'b1;
        addr[1]  = 8'd30;
        wdata[1] = 8'h33;
        wren[1]  = 1'b1;
        tick();
        chk_both("g1b_gnt", gnt1, gnt2, 4'b0010);
        chk_both("g1b_wren", mem_wren1, mem_wren2, 1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk_both("arst_wren", mem_wren1, mem_wren2, 0);
        chk_both("arst_gnt", gnt1, gnt2, 0);
        chk_both("arst_busy", busy1, busy2, 0);
        req  = '0;
        wren = '0;
        tick();
        reset_n = 1'b1;
        tick();

        // clear one cycle after a read: latency-1 strobe already out, latency-2 strobe flushed.
        req[2]  = 1'b1;
        addr[2] = 8'd5;
        tick();
        chk_both("g2c_gnt", gnt1, gnt2, 4'b0100);
        push_read(2, 8'h05, 1'b0);
        tick();
        clear = 1'b1;
        tick();
        chk_both("clr_busy", busy1, busy2, 0);
        chk_both("clr_gnt", gnt1, gnt2, 0);
        clear  = 1'b0;
        req[2] = 1'b0;
        repeat (3) tick();
        chk_both("post_clr_busy", busy1, busy2, 0);

        repeat (3) tick();
        chk("sb_empty_l1", exp_q1.size(), 0);
        chk("sb_empty_l2", exp_q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
